usb_rx_aligner: RTL
===================

USB_RX_ALIGNER -- requirements
Module: usb_rx_aligner

Interface
REQ-001 Parameter LANES, default 1, number of independent receive lanes (legal 1..4).
REQ-002 Parameter LOCK_COMMAS, default 3, number of same-offset commas needed to declare lock (legal 1..15).
REQ-003 Parameter ERR_LIMIT, default 4, number of errors in LOCKED that forces return to HUNT (legal 1..15).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_valid  input  1  qualifies rx_raw for the current cycle on all lanes.
REQ-007 rx_raw  input  LANES*10  unaligned 10-bit raw beat per lane; lane n uses bits [10n+9:10n]; bit 0 is the earliest received bit.
REQ-008 rx_pol_inv  input  LANES  per-lane polarity inversion; 1 means invert all 10 bits of that lane before any other processing.
REQ-009 rx_sym  output  LANES*10  aligned 10-bit symbol per lane, same lane packing as rx_raw.
REQ-010 rx_sym_valid  output  LANES  aligned symbol valid per lane.
REQ-011 rx_comma  output  LANES  rx_sym of that lane is K28.5 (0011111010 or 1100000101).
REQ-012 lane_locked  output  LANES  lane FSM is in LOCKED.
REQ-013 all_locked  output  1  AND of lane_locked.

Function
REQ-014 Each lane SHALL hold a 10-bit prev register, updated with the polarity-corrected beat on every rx_valid cycle and held otherwise.
REQ-015 Window per lane SHALL be w[19:0] = {cur, prev}; candidate at offset k (0..9) SHALL be w[k+9:k].
REQ-016 Comma search SHALL compare all 10 candidates against both K28.5 patterns; when several match, the lowest k SHALL win.
REQ-017 Symbol error SHALL be flagged when the candidate at the stored offset contains six or more consecutive equal bits.
REQ-018 Per-lane FSM states SHALL be HUNT, SYNC and LOCKED, with a 4-bit stored offset, a 4-bit comma count and a 4-bit error count.
REQ-019 FSM SHALL act only on rx_valid cycles; with rx_valid low, all lane state SHALL hold.
REQ-020 HUNT: a comma at any k SHALL set offset=k, comma count=1 and go to SYNC; otherwise stay in HUNT.
REQ-021 SYNC, comma at the stored offset: comma count SHALL increment, and the lane SHALL go to LOCKED with error count=0 when the count reaches LOCK_COMMAS.
REQ-022 SYNC, comma at a different offset: offset SHALL take the new k, comma count SHALL be 1, and the lane SHALL stay in SYNC.
REQ-023 SYNC, symbol error with no comma: the lane SHALL return to HUNT.
REQ-024 LOCKED: the offset SHALL be frozen.
REQ-025 LOCKED: a symbol error, or a comma at a different offset, SHALL increment the error count.
REQ-026 LOCKED: a comma at the stored offset SHALL clear the error count.
REQ-027 LOCKED: when the error count reaches ERR_LIMIT, the lane SHALL go to HUNT and clear its error count, offset and comma count in the same cycle.
REQ-028 LOCK_COMMAS=1 SHALL lock directly from SYNC on the next same-offset comma and SHALL not bypass SYNC.
REQ-029 Output latency SHALL be one cycle: for an rx_valid beat in cycle N, rx_sym, rx_sym_valid and rx_comma SHALL be registered and appear in cycle N+1.
REQ-030 rx_sym SHALL be the candidate at the offset in use in cycle N, after any offset update in that cycle is applied.
REQ-031 rx_sym_valid SHALL be 1 only when rx_valid was high in cycle N and the lane's next state is SYNC or LOCKED; otherwise it SHALL be 0 for one cycle.
REQ-032 rx_comma SHALL be qualified by rx_sym_valid.
REQ-033 lane_locked and all_locked SHALL be registered from the FSM state (no extra delay).
REQ-034 Lanes SHALL be fully independent; an error on one lane SHALL not affect another lane.
REQ-035 rx_pol_inv SHALL take effect on the beat sampled in the same cycle; changing it mid-stream SHALL not reset the FSM.

Reset
REQ-036 On rst=1 at a clk edge, every lane SHALL go to HUNT with prev=0, offset=0, comma count=0 and error count=0.
REQ-037 On reset, rx_sym=0, rx_sym_valid=0, rx_comma=0, lane_locked=0 and all_locked=0.
REQ-038 rst SHALL have priority over rx_valid in the same cycle; reset mid-lock SHALL drop lane_locked on the next edge.

Verification
REQ-039 LANES=1, stream of K28.5 (0011111010) repeated, shifted by 3 bits -> offset=3; lane_locked=1 after the third comma beat +1 cycle; rx_sym=0011111010 with rx_comma=1.
REQ-040 LANES=2, lane0 aligned, lane1 shifted by 7 with rx_pol_inv[1]=1 and inverted data -> both lanes lock; all_locked rises on the cycle after the later lane locks.
REQ-041 Locked lane, inject 4 symbols of 0000001111 -> lane_locked falls after the 4th error beat; the next comma relocks through SYNC.
REQ-042 In SYNC, comma at offset 2 then at offset 5 -> offset=5, comma count=1, state still SYNC, rx_sym_valid stays 1.
REQ-043 rx_valid toggled 1/0 each cycle during a lock sequence -> lock reached after the same number of valid beats; outputs hold state in invalid cycles with rx_sym_valid=0.
REQ-044 rst asserted for one cycle while LOCKED with rx_valid=1 -> all outputs 0 next cycle; relock requires LOCK_COMMAS fresh commas.

Source files
------------

// File: rtl/usb_rx_aligner_if.sv
// rtl/usb_rx_aligner_if.sv - receive-side bus bundle for the multi-lane 10b comma aligner
//
// Purpose: groups the raw receive beat, its qualifiers and the aligned outputs
// so the aligner and its source/sink share one connection.
// Ports (signals):
//   rx_valid      source -> aligner  qualifies rx_raw on all lanes this cycle
//   rx_raw        source -> aligner  LANES*10 unaligned beats, lane n at [10n+9:10n]
//   rx_pol_inv    source -> aligner  per-lane polarity inversion
//   rx_sym        aligner -> sink    LANES*10 aligned symbols, same packing
//   rx_sym_valid  aligner -> sink    per-lane aligned symbol valid
//   rx_comma      aligner -> sink    per-lane K28.5 indication (qualified)
//   lane_locked   aligner -> sink    per-lane LOCKED state
//   all_locked    aligner -> sink    AND of lane_locked
// Modports: master = beat source / symbol sink, slave = aligner.

interface usb_rx_aligner_if #(
  parameter int LANES = 1
);

  logic                  rx_valid;
  logic [LANES*10-1:0]   rx_raw;
  logic [LANES-1:0]      rx_pol_inv;
  logic [LANES*10-1:0]   rx_sym;
  logic [LANES-1:0]      rx_sym_valid;
  logic [LANES-1:0]      rx_comma;
  logic [LANES-1:0]      lane_locked;
  logic                  all_locked;

  modport master (
    output rx_valid,
    output rx_raw,
    output rx_pol_inv,
    input  rx_sym,
    input  rx_sym_valid,
    input  rx_comma,
    input  lane_locked,
    input  all_locked
  );

  modport slave (
    input  rx_valid,
    input  rx_raw,
    input  rx_pol_inv,
    output rx_sym,
    output rx_sym_valid,
    output rx_comma,
    output lane_locked,
    output all_locked
  );

endinterface

// File: rtl/usb_rx_aligner.sv
// rtl/usb_rx_aligner.sv - per-lane K28.5 comma search, HUNT/SYNC/LOCKED alignment and symbol extraction
//
// Purpose: aligns LANES independent 10-bit receive streams to K28.5 comma
// boundaries and emits aligned symbols one cycle after each valid beat.
// Parameters:
//   LANES        number of independent lanes (1..4)
//   LOCK_COMMAS  same-offset commas needed to declare lock (1..15)
//   ERR_LIMIT    errors tolerated in LOCKED before returning to HUNT (1..15)
// Ports:
//   clk  clock for all logic
//   rst  synchronous active-high reset
//   bus  usb_rx_aligner_if.slave (raw beats in, aligned symbols/lock status out)

module usb_rx_aligner #(
  parameter int LANES       = 1,
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  usb_rx_aligner_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  // Five-bit thresholds so count+1 can be compared without wrapping at 15.
  localparam logic [4:0] LOCK_N = 5'(LOCK_COMMAS);
  localparam logic [4:0] ERR_N  = 5'(ERR_LIMIT);

  function automatic logic is_comma(input logic [9:0] c);
    return (c == K28_5_NEG) || (c == K28_5_POS);
  endfunction

  // Run of six or more identical bits anywhere in the symbol.
  function automatic logic has_run6(input logic [9:0] c);
    logic r;
    r = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if ((c[i +: 6] == 6'b111111) || (c[i +: 6] == 6'b000000)) begin
        r = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] pick(input logic [19:0] w, input logic [3:0] k);
    return 10'(w >> k);
  endfunction

  logic [LANES-1:0] locked_vec;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    state_t      state_q, state_d;
    logic [9:0]  prev_q;
    logic [9:0]  cur;
    logic [19:0] win;
    logic [3:0]  off_q, off_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  hit_k;
    logic        hit_any;
    logic [9:0]  cand_off;
    logic        comma_at_off;
    logic        sym_err;
    logic [9:0]  sym_d, sym_q;
    logic        valid_d, valid_q;
    logic        comma_d, comma_q;

    // Polarity is corrected before the window so prev always holds true-sense bits.
    assign cur = bus.rx_raw[10*n +: 10] ^ {10{bus.rx_pol_inv[n]}};
    assign win = {cur, prev_q};

    // Scan from the top so the lowest matching offset is the one left standing.
    always_comb begin : comma_search
      hit_any = 1'b0;
      hit_k   = 4'd0;
      for (int k = 9; k >= 0; k--) begin
        if (is_comma(win[k +: 10])) begin
          hit_any = 1'b1;
          hit_k   = 4'(k);
        end
      end
    end

    assign cand_off     = pick(win, off_q);
    assign comma_at_off = is_comma(cand_off);
    assign sym_err      = has_run6(cand_off);

    always_comb begin : next_state
      state_d = state_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (bus.rx_valid) begin
        unique case (state_q)
          HUNT: begin
            if (hit_any) begin
              state_d = SYNC;
              off_d   = hit_k;
              cnt_d   = 4'd1;
            end
          end
          SYNC: begin
            if (comma_at_off) begin
              cnt_d = cnt_q + 4'd1;
              if (({1'b0, cnt_q} + 5'd1) >= LOCK_N) begin
                state_d = LOCKED;
                err_d   = 4'd0;
              end
            end else if (hit_any) begin
              // Comma moved: restart the count at the new boundary.
              off_d = hit_k;
              cnt_d = 4'd1;
            end else if (sym_err) begin
              state_d = HUNT;
              off_d   = 4'd0;
              cnt_d   = 4'd0;
            end
          end
          LOCKED: begin
            if (comma_at_off) begin
              err_d = 4'd0;
            end else if (sym_err || hit_any) begin
              if (({1'b0, err_q} + 5'd1) >= ERR_N) begin
                state_d = HUNT;
                err_d   = 4'd0;
                off_d   = 4'd0;
                cnt_d   = 4'd0;
              end else begin
                err_d = err_q + 4'd1;
              end
            end
          end
          default: begin
            state_d = HUNT;
            off_d   = 4'd0;
            cnt_d   = 4'd0;
            err_d   = 4'd0;
          end
        endcase
      end
    end

    // Output symbol uses the offset after this cycle's update, so the beat that
    // first finds a comma is already emitted aligned.
    assign sym_d   = pick(win, off_d);
    assign valid_d = bus.rx_valid && (state_d != HUNT);
    assign comma_d = valid_d && is_comma(sym_d);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= HUNT;
        prev_q  <= 10'd0;
        off_q   <= 4'd0;
        cnt_q   <= 4'd0;
        err_q   <= 4'd0;
        sym_q   <= 10'd0;
        valid_q <= 1'b0;
        comma_q <= 1'b0;
      end else begin
        state_q <= state_d;
        off_q   <= off_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
        valid_q <= valid_d;
        comma_q <= comma_d;
        if (bus.rx_valid) begin
          prev_q <= cur;
          sym_q  <= sym_d;
        end
      end
    end

    assign bus.rx_sym[10*n +: 10] = sym_q;
    assign bus.rx_sym_valid[n]    = valid_q;
    assign bus.rx_comma[n]        = comma_q;
    assign locked_vec[n]          = (state_q == LOCKED);
  end

  assign bus.lane_locked = locked_vec;
  assign bus.all_locked  = &locked_vec;

endmodule
